// File: rtl/pipe_buf32.sv
// rtl/pipe_buf32.sv - elastic valid/ready pipeline buffer with flush
module pipe_buf32 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic push;
    logic pop;

    // Status is decoded only from the stored count, so nothing on the input
    // side reaches the output side within a cycle.
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rp_q];
    assign count     = count_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Next-state for pointers and occupancy; flush wins over any transfer.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wp_d = wp_q + 1'b1;
            end
            if (pop) begin
                rp_d = rp_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Entry storage; cleared on reset so out_data reads zero, untouched by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush) begin
            mem_q[wp_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_buf32.sv
// tb/tb_pipe_buf32.sv - scoreboard bench for pipe_buf32
module tb_pipe_buf32;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a plain FIFO of expected words plus an occupancy figure.
    logic [WIDTH-1:0] exp_q[$];
    int               mcount = 0;

    pipe_buf32 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and advance the model at the clock edge.
    task automatic step(input logic iv, input logic [31:0] d, input logic ordy,
                        input logic fl, output logic acc);
        logic pp;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        acc = iv && (mcount < DEPTH) && !fl;
        pp  = ordy && (mcount > 0);
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
            mcount = 0;
        end else begin
            if (acc) exp_q.push_back(d);
            mcount = mcount + int'(acc) - int'(pp);
        end
        #1;
    endtask

    task automatic s(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        logic a;
        step(iv, d, ordy, fl, a);
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 2; k++) s(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    // Monitor: compare status every cycle and the head word whenever one is presented.
    initial begin
        forever begin
            @(negedge clk);
            chk("count", 32'(count), 32'(mcount));
            chk("in_ready", 32'(in_ready), 32'(mcount != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(mcount != 0));
            if (count > CW'(DEPTH)) chk("count_max", 32'(count), DEPTH);
            if (rst) begin
                chk("out_data_rst", out_data, 32'h0);
            end else if (exp_q.size() > 0) begin
                chk("out_data", out_data, exp_q[0]);
                if (out_ready && !flush) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic acc;
        int   n, stalls, cyc;
        logic ordy;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_count", 32'(count), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Basic latency.
        s(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("latency_valid", 32'(out_valid), 32'h1);
        chk("latency_data", out_data, 32'hDEADBEEF);
        s(1'b0, 32'h0, 1'b1, 1'b0);

        // Fill to full, then offer 0x5 while full.
        for (int v = 1; v <= 4; v++) s(1'b1, 32'(v), 1'b0, 1'b0);
        s(1'b1, 32'h5, 1'b0, 1'b0);
        s(1'b1, 32'h5, 1'b0, 1'b0);
        s(1'b1, 32'h5, 1'b1, 1'b0);
        s(1'b1, 32'h5, 1'b1, 1'b0);
        drain();

        // Simultaneous push and pop at count 2.
        s(1'b1, 32'hA, 1'b0, 1'b0);
        s(1'b1, 32'hB, 1'b0, 1'b0);
        s(1'b1, 32'hC, 1'b1, 1'b0);
        drain();

        // Streaming 0..9 through the wrap with stalls.
        n = 0; stalls = 0; cyc = 0;
        while ((n < 10 || mcount > 0) && cyc < 300) begin
            if (stalls < 10) ordy = ($urandom_range(0, 2) == 0);
            else             ordy = 1'($urandom_range(0, 1));
            if (!ordy && mcount > 0) stalls++;
            step(n < 10, 32'(n), ordy, 1'b0, acc);
            if (acc) n++;
            cyc++;
        end
        chk("wrap_words", 32'(n), 32'd10);
        chk("wrap_finished", 32'(cyc < 300), 32'h1);

        // Flush priority.
        for (int v = 1; v <= 3; v++) s(1'b1, 32'h10 + 32'(v), 1'b0, 1'b0);
        s(1'b1, 32'h77, 1'b1, 1'b1);
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_valid", 32'(out_valid), 32'h0);
        s(1'b1, 32'h55, 1'b0, 1'b0);
        chk("flush_next", out_data, 32'h55);
        drain();

        // Randomised traffic with occasional flush.
        for (int k = 0; k < 80; k++)
            s(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 15) == 0);
        drain();

        // Asynchronous reset between edges.
        for (int v = 1; v <= 3; v++) s(1'b1, 32'h20 + 32'(v), 1'b0, 1'b0);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        exp_q.delete();
        mcount = 0;
        #1;
        chk("arst_count", 32'(count), 32'h0);
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_data", out_data, 32'h0);
        #1 rst = 1'b0;
        s(1'b1, 32'h99, 1'b0, 1'b0);
        chk("arst_resume", out_data, 32'h99);
        s(1'b1, 32'h9A, 1'b1, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
